// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: M/W pipeline inputs, decode read ports,
// forwarding outputs and status.
interface wb_regfile_if;
    logic        writeEn_IN;
    logic        memRead_IN;
    logic [2:0]  writeRegSel_IN;
    logic [15:0] execData_IN;
    logic [15:0] memData_IN;
    logic        halt_IN;
    logic [2:0]  readReg1Sel;
    logic [2:0]  readReg2Sel;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic [15:0] wbData;
    logic [2:0]  wbRegSel;
    logic        wbValid;
    logic        halted;
    logic [15:0] writeCount;

    modport master (
        output writeEn_IN, memRead_IN, writeRegSel_IN, execData_IN, memData_IN,
               halt_IN, readReg1Sel, readReg2Sel,
        input  readData1, readData2, wbData, wbRegSel, wbValid, halted, writeCount
    );

    modport slave (
        input  writeEn_IN, memRead_IN, writeRegSel_IN, execData_IN, memData_IN,
               halt_IN, readReg1Sel, readReg2Sel,
        output readData1, readData2, wbData, wbRegSel, wbValid, halted, writeCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to an 8 x 16-bit
// register file with same-cycle read bypass, and tracks halt and write count.
module wb_regfile (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    logic [15:0] regs [8];
    logic [15:0] write_count;
    logic [15:0] wb_data;
    logic        wb_valid;

    assign wb_data  = bus.memRead_IN ? bus.memData_IN : bus.execData_IN;
    // A halt in writeback kills its own write as well as everything after it.
    assign wb_valid = bus.writeEn_IN & ~bus.halt_IN & (state == RUN);

    assign bus.wbData     = wb_data;
    assign bus.wbRegSel   = bus.writeRegSel_IN;
    assign bus.wbValid    = wb_valid;
    assign bus.halted     = (state == HALTED);
    assign bus.writeCount = write_count;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bus.readData1 = regs[bus.readReg1Sel];
        bus.readData2 = regs[bus.readReg2Sel];
        if (wb_valid && bus.readReg1Sel == bus.writeRegSel_IN) bus.readData1 = wb_data;
        if (wb_valid && bus.readReg2Sel == bus.writeRegSel_IN) bus.readData2 = wb_data;
    end

    // NOTE: non-blocking assignments for all state; the register array is reset
    // because software may read registers it never wrote and expects zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            write_count <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (state == RUN && bus.halt_IN) state <= HALTED;
            if (wb_valid) begin
                regs[bus.writeRegSel_IN] <= wb_data;
                if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            end
        end
    end
endmodule
